switch_route_sequencer: RTL

- Avalon-MM master that programs the 8x8 video stream switch on behalf of a host request port.
- At start-up it enables the switch and loads the consume mode.
- Each routing request is staged into the target output's next-route register and committed only at a frame boundary (endofpacket handshake on that output) or on timeout.
- Sits beside the switch, driving its 5-bit control port; host is a CPU/config FSM.

---
 rtl/switch_seq_pkg.sv | 28 ++
 rtl/switch_seq_timeout.sv | 28 ++
 rtl/switch_route_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_seq_pkg.sv
// Shared constants, state encoding and helpers for the video switch route sequencer.
// SWITCH_SEQ_READBACK_EN adds the CHECK/CHECK_WAIT readback states.
package switch_seq_pkg;

    localparam logic [4:0] ADDR_CTRL       = 5'd0;
    localparam logic [4:0] ADDR_COMMIT     = 5'd3;
    localparam logic [4:0] ADDR_ROUTE_BASE = 5'd4;
    localparam logic [4:0] ADDR_CONSUME    = 5'd16;

    typedef enum logic [3:0] {
        INIT_EN,
        INIT_CM,
        IDLE,
        STAGE,
`ifdef SWITCH_SEQ_READBACK_EN
        CHECK,
        CHECK_WAIT,
`endif
        WAIT_EOP,
        COMMIT,
        GAP
    } seq_state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/switch_seq_timeout.sv
// Frame-boundary timeout counter: cleared per request, counts while enabled,
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module switch_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/switch_route_sequencer.sv
// Avalon-MM master that initialises the 8x8 video switch and applies host route
// requests at frame boundaries. Optional readback check: SWITCH_SEQ_READBACK_EN.
module switch_route_sequencer
    import switch_seq_pkg::*;
#(
    parameter int NUM_PORTS      = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] cfg_consume_mode,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_output,
    input  logic [2:0]           req_input,
    input  logic                 req_disable,
    input  logic [NUM_PORTS-1:0] tap_valid,
    input  logic [NUM_PORTS-1:0] tap_ready,
    input  logic [NUM_PORTS-1:0] tap_eop,
    output logic                 m_write,
    output logic                 m_read,
    output logic [4:0]           m_address,
    output logic [31:0]          m_writedata,
    input  logic [31:0]          m_readdata,
    output logic                 done,
    output logic                 timeout_flag,
    output logic                 err
);

    seq_state_t r_state;
    seq_state_t w_next_state;
    logic       r_started;
    logic [2:0] r_out;
    logic [7:0] r_word;
    logic       r_done;
    logic       r_timeout_flag;

    logic w_accept;
    logic w_to_clear;
    logic w_to_enable;
    logic w_to_expired;
    logic w_flag_set;
    logic w_flag_clr;
    logic w_done_set;
    logic w_err_set;
    logic w_boundary;
    logic w_unused_readdata;

    assign w_boundary        = tap_valid[r_out] & tap_ready[r_out] & tap_eop[r_out];
    assign w_unused_readdata = ^m_readdata;

    switch_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_to_clear),
        .i_enable (w_to_enable),
        .o_expired(w_to_expired)
    );

    // r_started keeps the INIT_EN write off the bus while reset is still asserted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= INIT_EN;
            r_started      <= 1'b0;
            r_out          <= '0;
            r_word         <= '0;
            r_done         <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_started <= 1'b1;
            r_done    <= w_done_set;
            if (w_accept) begin
                r_out  <= req_output;
                r_word <= req_disable ? 8'h00 : onehot8(req_input);
            end
            if (w_flag_set) begin
                r_timeout_flag <= 1'b1;
            end else if (w_flag_clr) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        w_accept     = 1'b0;
        w_to_clear   = 1'b0;
        w_to_enable  = 1'b0;
        w_flag_set   = 1'b0;
        w_flag_clr   = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            INIT_EN: begin
                if (r_started) begin
                    m_write      = 1'b1;
                    m_address    = ADDR_CTRL;
                    m_writedata  = 32'd1;
                    w_next_state = INIT_CM;
                end
            end
            INIT_CM: begin
                m_write      = 1'b1;
                m_address    = ADDR_CONSUME;
                m_writedata  = 32'(cfg_consume_mode);
                w_next_state = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_to_clear   = 1'b1;
                    w_next_state = STAGE;
                end
            end
            // The timeout window runs from the staging write, so STAGE counts too
            STAGE: begin
                m_write     = 1'b1;
                m_address   = ADDR_ROUTE_BASE + {2'b00, r_out};
                m_writedata = {24'b0, r_word};
                w_to_enable = 1'b1;
`ifdef SWITCH_SEQ_READBACK_EN
                w_next_state = CHECK;
`else
                w_next_state = WAIT_EOP;
`endif
            end
`ifdef SWITCH_SEQ_READBACK_EN
            CHECK: begin
                m_read       = 1'b1;
                m_address    = ADDR_ROUTE_BASE + {2'b00, r_out};
                w_to_enable  = 1'b1;
                w_next_state = CHECK_WAIT;
            end
            CHECK_WAIT: begin
                w_to_enable = 1'b1;
                if (m_readdata[7:0] != r_word) begin
                    w_err_set    = 1'b1;
                    w_done_set   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_EOP;
                end
            end
`endif
            // A boundary wins over a coincident timeout
            WAIT_EOP: begin
                w_to_enable = 1'b1;
                if (w_boundary) begin
                    w_flag_clr   = 1'b1;
                    w_next_state = COMMIT;
                end else if (w_to_expired) begin
                    w_flag_set   = 1'b1;
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                m_write      = 1'b1;
                m_address    = ADDR_COMMIT;
                m_writedata  = 32'd1;
                w_next_state = GAP;
            end
            GAP: begin
                w_done_set   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = INIT_EN;
        endcase
    end

`ifdef SWITCH_SEQ_READBACK_EN
    logic r_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign done         = r_done;
    assign timeout_flag = r_timeout_flag;

endmodule
